// File: rtl/uart_pkg.sv
// Shared UART receive types and oversampling constants.
// Used by uart_rx; the UART_RX_MAJORITY_EN build option lives in uart_rx.sv.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int DATA_BITS_DEF   = 8;
  localparam int OVERSAMPLE_MID  = 7;
  localparam int OVERSAMPLE_LAST = 15;

  function automatic logic maj3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs; resets to 1 (idle-high lines).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on a shared oversampling tick, with start validation and frame-error flag.
// Build option: define UART_RX_MAJORITY_EN to decide on a 3-sample majority instead of one sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_LAST + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TICK_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam int TICK_MID  = (OVERSAMPLE * (OVERSAMPLE_MID + 1)) / (OVERSAMPLE_LAST + 1) - 1;
  localparam int TICK_LAST = OVERSAMPLE - 1;

  logic                 rx_s;
  logic                 sample;
  rx_state_t            state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q;
  logic                 rx_busy_q;
  logic                 frame_err_q;
  logic                 armed_q;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two ticks of history plus the current sample form the 3-wide voting window.
  logic [1:0] win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= 2'b11;
    end else if (b_tick) begin
      win_q <= {win_q[0], rx_s};
    end
  end

  assign sample = maj3({win_q, rx_s});
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_s) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          // Edge detection runs every clk so the mid-bit point is tick-accurate.
          if (armed_q && !rx_s) begin
            tick_cnt_q <= '0;
            state_q    <= START;
            rx_busy_q  <= 1'b1;
          end
        end
        START: begin
          if (b_tick) begin
            if (tick_cnt_q == TICK_W'(TICK_MID)) begin
              if (!sample) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                state_q    <= DATA;
              end else begin
                state_q   <= IDLE;
                rx_busy_q <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (tick_cnt_q == TICK_W'(TICK_LAST)) begin
              shreg_q    <= {sample, shreg_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                state_q <= STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (b_tick) begin
            if (tick_cnt_q == TICK_W'(TICK_LAST)) begin
              state_q    <= IDLE;
              rx_busy_q  <= 1'b0;
              tick_cnt_q <= '0;
              if (sample) begin
                rx_data_q <= shreg_q;
                rx_done_q <= 1'b1;
              end else begin
                // Disarm so a held-low break cannot look like a new start bit.
                frame_err_q <= 1'b1;
                armed_q     <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick-accurate frame driver, queue scoreboard on rx_done.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int         checks = 0;
  int         fails = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         tick_div = 0;
  logic [7:0] ferr_data = 8'h00;
  bit         busy_seen = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .b_tick    (b_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // One-clk tick every 10 clocks, changed on the falling edge so it is stable at posedge.
  initial forever begin
    @(negedge clk);
    b_tick = (tick_div == 9);
    tick_div = (tick_div == 9) ? 0 : tick_div + 1;
  end

  // Scoreboard monitor: pops one expected byte per rx_done pulse.
  initial forever begin
    @(negedge clk);
    if (rx_busy) busy_seen = 1'b1;
    if (rx_done) begin
      logic [7:0] exp_b;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rx_done: got rx_data=%02h, required no strobe", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          fails++;
          $display("FAIL rx_data: got %02h, required %02h", rx_data, exp_b);
        end
      end
      checks++;
      if (frame_err !== 1'b0 || prev_done !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse: frame_err=%b prev_done=%b, required 0 0", frame_err, prev_done);
      end
      checks++;
      if (rx_busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_at_done: got %b, required 0", rx_busy);
      end
      $display("rx_done   data=%02h t=%0t", rx_data, $time);
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_data = rx_data;
      checks++;
      if (rx_done !== 1'b0 || rx_busy !== 1'b0 || prev_ferr !== 1'b0) begin
        fails++;
        $display("FAIL ferr_pulse: rx_done=%b rx_busy=%b prev_ferr=%b, required 0 0 0",
                 rx_done, rx_busy, prev_ferr);
      end
      $display("frame_err data=%02h t=%0t", rx_data, $time);
    end
    prev_done = rx_done;
    prev_ferr = frame_err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (b_tick !== 1'b1 && n < 50);
    if (n >= 50) begin
      fails++;
      $display("FAIL tick_timeout: got no b_tick in 50 clk, required one every 10");
    end
    #1;
  endtask

  task automatic drive_slots(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v;
      wait_tick();
    end
  endtask

  // Each slot is one tick period; slot 7+16k is the DUT's decision tick for bit k.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int glitch_slot, input int abort_slot);
    logic v;
    for (int s = 0; s < 160; s++) begin
      if (s == abort_slot) return;
      if (s < 16) v = 1'b0;
      else if (s < 144) v = d[(s - 16) / 16];
      else v = stop_bit;
      if (s == glitch_slot) v = 1'b1;
      rx = v;
      wait_tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %02h, required 00", rx_data); end
    checks++; if (rx_done !== 1'b0) begin fails++; $display("FAIL reset_rx_done: got %b, required 0", rx_done); end
    checks++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_rx_busy: got %b, required 0", rx_busy); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    rst_n = 1'b1;
    drive_slots(1'b1, 20);
    checks++; if (rx_busy !== 1'b0 || done_cnt != 0) begin fails++; $display("FAIL idle_after_reset: busy=%b done_cnt=%0d, required 0 0", rx_busy, done_cnt); end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1, -1);
    drive_slots(1'b1, 4);
    checks++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL basic_done_count: got %0d, required %0d", done_cnt - d0, 1); end
    checks++; if (ferr_cnt != f0) begin fails++; $display("FAIL basic_no_ferr: got %0d, required 0", ferr_cnt - f0); end
    checks++; if (rx_data !== 8'h55) begin fails++; $display("FAIL basic_hold: got %02h, required 55", rx_data); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, -1, -1);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, -1, -1);
    drive_slots(1'b1, 4);
    checks++; if (done_cnt != d0 + 2) begin fails++; $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_queue: got %0d left, required 0", exp_q.size()); end
    checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL b2b_last: got %02h, required 00", rx_data); end
  endtask

  task automatic test_start_glitch();
    int d0 = done_cnt;
    busy_seen = 1'b0;
    drive_slots(1'b0, 4);
    drive_slots(1'b1, 20);
    checks++; if (busy_seen !== 1'b1) begin fails++; $display("FAIL glitch_busy_seen: got %b, required 1", busy_seen); end
    checks++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_back_idle: got busy=%b, required 0", rx_busy); end
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL glitch_no_done: got %0d, required 0", done_cnt - d0); end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    drive_slots(1'b1, 4);
    checks++; if (done_cnt != d0 + 1 || rx_data !== 8'h3C) begin fails++; $display("FAIL glitch_next_frame: got count=%0d data=%02h, required 1 3c", done_cnt - d0, rx_data); end
  endtask

  task automatic test_frame_error();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, -1);
    drive_slots(1'b0, 40);
    drive_slots(1'b1, 16);
    checks++; if (ferr_cnt != f0 + 1) begin fails++; $display("FAIL ferr_count: got %0d, required 1", ferr_cnt - f0); end
    checks++; if (ferr_data !== 8'h3C) begin fails++; $display("FAIL ferr_data_held: got %02h, required 3c", ferr_data); end
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL ferr_break_no_done: got %0d, required 0", done_cnt - d0); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, -1);
    drive_slots(1'b1, 4);
    checks++; if (done_cnt != d0 + 1 || ferr_cnt != f0 + 1) begin fails++; $display("FAIL ferr_after: got done=%0d ferr=%0d, required 1 1", done_cnt - d0, ferr_cnt - f0); end
    checks++; if (rx_data !== 8'h81) begin fails++; $display("FAIL ferr_next_data: got %02h, required 81", rx_data); end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    drive_slots(1'b1, 10);
    send_frame(8'hC9, 1'b1, -1, 70);
    checks++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b, required 1", rx_busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (rx_busy !== 1'b0 || rx_data !== 8'h00) begin fails++; $display("FAIL mid_reset_vals: got busy=%b data=%02h, required 0 00", rx_busy, rx_data); end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_slots(1'b1, 20);
    checks++; if (done_cnt != d0 || ferr_cnt != 1) begin fails++; $display("FAIL mid_no_strobe: got done=%0d ferr=%0d, required 0 1", done_cnt - d0, ferr_cnt); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1, -1);
    drive_slots(1'b1, 4);
    checks++; if (rx_data !== 8'h7E || done_cnt != d0 + 1) begin fails++; $display("FAIL mid_next_frame: got data=%02h count=%0d, required 7e 1", rx_data, done_cnt - d0); end
  endtask

  task automatic test_bit_glitch();
    logic [7:0] exp_b;
`ifdef UART_RX_MAJORITY_EN
    exp_b = 8'h00;
`else
    exp_b = 8'h04;
`endif
    drive_slots(1'b1, 20);
    exp_q.push_back(exp_b);
    send_frame(8'h00, 1'b1, 7 + 16 * 3, -1);
    drive_slots(1'b1, 4);
    checks++; if (rx_data !== exp_b) begin fails++; $display("FAIL bit_glitch: got %02h, required %02h", rx_data, exp_b); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_glitch();
    test_frame_error();
    test_reset_mid();
    test_bit_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the host serial link. It recovers 8N1 frames from the asynchronous `rx` line using the shared 16x oversampling tick, `b_tick`, and presents each byte with a one-cycle `rx_done` strobe. It is the receive counterpart of the existing UART transmitter and shares the same baud generator. It feeds the command decoder that selects filter and piano modes.

## Interface
Parameters:
- `DATA_BITS`, default 8: payload bits per frame, sent LSB first.
- `OVERSAMPLE`, default 16: `b_tick` pulses per bit period.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `b_tick`  in  1: oversample enable, one `clk` wide, at 16x the baud rate.
- `rx`  in  1: raw serial line, asynchronous, idles high.
- `rx_data`  out  8: last good byte; holds until the next good frame.
- `rx_done`  out  1: one-cycle pulse when `rx_data` updates.
- `rx_busy`  out  1: high from start-edge detection until return to IDLE.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.

## Operation
- `rx` passes through a 2-FF synchronizer to give `rx_s`; all decisions use `rx_s`.
- `tick_cnt` is 4 bits; `bit_cnt` is 3 bits. Both advance only on `b_tick`.
- IDLE:
  - If `armed` and `rx_s==0`: clear `tick_cnt`, go to START, set `rx_busy`.
  - `armed` is set whenever `rx_s==1`.
- START (mid-bit validation):
  - On `b_tick` with `tick_cnt==7`: if `rx_s==0`, clear `tick_cnt` and `bit_cnt`, go to DATA.
  - Otherwise the start was a glitch: go to IDLE with no strobe.
- DATA:
  - On `b_tick` with `tick_cnt==15`: shift in the sample (`shreg <= {sample, shreg[7:1]}`) and clear `tick_cnt`.
  - When `bit_cnt==7`, go to STOP; otherwise increment `bit_cnt`.
- STOP:
  - On `b_tick` with `tick_cnt==15`, sample the stop bit and go to IDLE. This is mid-stop-bit, which allows resync for a back-to-back start.
  - Stop bit 1: `rx_data <= shreg`, pulse `rx_done`.
  - Stop bit 0: pulse `frame_err`, leave `rx_data` unchanged, clear `armed`. A break (line held low) therefore does not retrigger until the line returns high.
- `rx_done` and `frame_err` are mutually exclusive.
- `sample` is `rx_s`, or the majority value when the macro is defined (see Configuration).

## Timing
- Reset values: `rx_data=8'h00`, `rx_done=0`, `rx_busy=0`, `frame_err=0`, state IDLE, counters 0, `armed=1`. The synchronizer flops reset to 1.
- Synchronizer latency is 2 `clk` cycles.
- Start-edge detection happens on any `clk` edge; it is not gated by `b_tick`.
- Data bits are sampled 8+16k ticks after the detected edge.
- `rx_done` and `frame_err` are registered. Each goes high on the edge of the stop-sample `b_tick` and lasts exactly one `clk`.
- `rx_busy` falls on the same edge that `rx_done` or `frame_err` rises.
- `rx_data` is valid the same cycle `rx_done` is high.
- Reset asserted mid-frame: everything returns to reset values immediately and no strobe is produced. The frame is then picked up from the next high-to-low edge.
- `b_tick` held low: the FSM freezes in its current state with no timeout.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Keep a 3-bit window of `rx_s`, shifted on each `b_tick`.
  - `sample` is the majority of that window. It is used for the START check, data bits and the stop bit.
  - A glitch lasting one tick is rejected.
- Not defined: `sample` is `rx_s` at the decision tick. The window register is not built.

## Structure
- `uart_pkg` holds:
  - the `rx_state_t` enum `{IDLE, START, DATA, STOP}`;
  - `OVERSAMPLE_MID=7` and `OVERSAMPLE_LAST=15`;
  - the default `DATA_BITS`.
- One sub-module, `sync_2ff`, a generic 1-bit synchronizer with reset value 1. It is reused for other asynchronous inputs.

## Test plan
- Frame 0x55, `b_tick` every 10 `clk` -> `rx_data=0x55`, `rx_done` high for 1 cycle, `frame_err` stays 0.
- Back-to-back frames 0xA3 then 0x00, one stop bit each -> two `rx_done` pulses, with `rx_data` 0xA3 then 0x00.
- Start glitch: `rx` low for 4 ticks -> `rx_busy` pulses, no `rx_done`, FSM returns to IDLE, and the following 0x3C frame is received.
- Frame 0x3C with stop bit 0, then line low for 40 ticks, then frame 0x81 -> one `frame_err` pulse with `rx_data` unchanged; the only subsequent `rx_done` carries 0x81.
- `rst_n` low during data bit 3 -> outputs go to reset values immediately; the next frame 0x7E gives `rx_data=0x7E`.
- One-tick high glitch at mid-bit 2 of 0x00 -> `rx_data=0x00` with `UART_RX_MAJORITY_EN` defined, and 0x04 without it.
